multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Next-generation control unit for the multicycle MIPS datapath.
- Merges the main-control FSM and the ALU decode into one block.
- Widens the instruction set to R-type, lw, sw, beq, bne, addi, andi, ori and j.
- Adds a memory wait handshake, an instruction-retire pulse and counter, and a parametrised ALU-control width.

Parameters:
ALUC_W, 3, width of alu_control; must be >=3; bits above [2:0] are driven 0.
CNT_W, 16, width of instr_count.
MEM_WAIT, 1, 1 = memory states wait on mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26], read from the IR
funct  in  6  instr[5:0], read from the IR
mem_ready  in  1  memory access completes this cycle
mem_to_reg, reg_dst, i_or_d, alu_src_a, zero_ext  out  1  datapath mux selects; zero_ext=1 zero-extends imm
alu_src_b  out  2  00 B, 01 const 4, 10 signext/zeroext imm, 11 imm<<2
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
ir_write, pc_write, mem_write, reg_write, branch, branch_ne  out  1  write/branch strobes
alu_control  out  ALUC_W  000 and, 001 or, 010 add, 110 sub, 111 slt
state  out  4  current state, for debug
instr_done  out  1  one-cycle pulse on an instruction's final cycle
instr_count  out  CNT_W  count of retired instructions

Behaviour:
- Moore FSM. States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, ALUWB 7, BRANCH 8, EXEC_I 9, IWB 10, JUMP 11, TRAP 12.
- Unlisted outputs are 0 in every state. alu_control defaults to add (010).
- Reset: state=FETCH, instr_count=0.
  - While rst_n=0, all strobes are 0 (ir_write, pc_write, mem_write, reg_write, branch, branch_ne, instr_done).
  - Selects take their FETCH values.
  - Reset mid-access aborts the instruction with no write.
- FETCH: alu_src_b=01, add; ir_write=pc_write=mem_ready. Holds while mem_ready=0; next state DECODE.
- DECODE: alu_src_b=11, add. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC_R
  - 000100 or 000101 -> BRANCH
  - 001000, 001100 or 001101 -> EXEC_I
  - 000010 -> JUMP
  - any other opcode -> FETCH, with no retire
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: i_or_d=1; holds until mem_ready; next state MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, retire.
- MEMWR: i_or_d=1, mem_write=1 held until mem_ready; retire on the mem_ready cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00. funct mapping:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010
  - next state ALUWB
- ALUWB: reg_dst=1, reg_write=1, retire.
- EXEC_I: alu_src_a=1, alu_src_b=10. addi -> add; andi -> and with zero_ext=1; ori -> or with zero_ext=1. Next state IWB.
- IWB: reg_write=1, zero_ext held from EXEC_I, retire.
- BRANCH: alu_src_a=1, sub, pc_src=01. branch=1 for beq, branch_ne=1 for bne. Retire.
- JUMP: pc_src=10, pc_write=1, retire.
- Retire means instr_done=1 for that cycle, the next state is FETCH, and instr_count increments, wrapping 2^CNT_W-1 -> 0.
- Latencies with mem_ready always 1 (cycles): lw 5, sw 4, R 4, I 4, branch 3, j 3.
- The opcode may change during FETCH; it is sampled only in DECODE and MEMADR/EXEC_I/BRANCH. The IR is stable after FETCH.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE, or an unknown funct in EXEC_R, moves to TRAP. TRAP holds all strobes 0 and exits only on reset. An extra output illegal (1 bit) is 1 in TRAP.
- Undefined: unknown opcodes return to FETCH without retiring, unknown functs execute as add, and there is no illegal port.

Test Plan:
- Reset with mem_ready=1, then an add R-type (funct 100000) -> states 0,1,6,7,0; alu_control 010 in EXEC_R; reg_write and reg_dst =1 in ALUWB; instr_count=1.
- lw with mem_ready low for 3 cycles in MEMRD -> state stays 3 for 3 cycles, then MEMWB has mem_to_reg=1, reg_write=1; total 8 cycles.
- sw -> mem_write=1 in MEMWR only, reg_write never 1, instr_done pulses once.
- bne (000101) -> in BRANCH, branch_ne=1, branch=0, alu_control=110, pc_src=01. j -> pc_src=10, pc_write=1.
- ori (001101) -> zero_ext=1 in EXEC_I and IWB, alu_control=001, reg_dst=0.
- rst_n pulled low mid-MEMWR -> asynchronously state=0, mem_write=0, count=0. Opcode 111111 -> back to FETCH with count unchanged, or TRAP with illegal=1 when CTRL_ILLEGAL_TRAP_EN is defined.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit port bundle: IR fields and memory handshake in, datapath selects, strobes and debug out.
// The illegal signal exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_fsm_if #(
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              mem_ready;

    logic              mem_to_reg;
    logic              reg_dst;
    logic              i_or_d;
    logic              alu_src_a;
    logic              zero_ext;
    logic [1:0]        alu_src_b;
    logic [1:0]        pc_src;
    logic              ir_write;
    logic              pc_write;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
    logic              branch_ne;
    logic [ALUC_W-1:0] alu_control;
    logic [3:0]        state;
    logic              instr_done;
    logic [CNT_W-1:0]  instr_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic              illegal;
`endif

    modport master (
        input  opcode, funct, mem_ready,
        output mem_to_reg, reg_dst, i_or_d, alu_src_a, zero_ext, alu_src_b, pc_src,
               ir_write, pc_write, mem_write, reg_write, branch, branch_ne,
               alu_control, state, instr_done, instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
        , illegal
`endif
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_to_reg, reg_dst, i_or_d, alu_src_a, zero_ext, alu_src_b, pc_src,
               ir_write, pc_write, mem_write, reg_write, branch, branch_ne,
               alu_control, state, instr_done, instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
        , illegal
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS main control + ALU decode; lw 5, sw/R/I 4, beq/bne/j 3 cycles, memory states stall on mem_ready.
// Define CTRL_ILLEGAL_TRAP_EN to send unknown opcodes/functs to a TRAP state with an illegal output.
module multicycle_ctrl_fsm #(
    parameter int ALUC_W   = 3,
    parameter int CNT_W    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_fsm_if.master  bus
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC_R = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] EXEC_I = 4'd9;
    localparam logic [3:0] IWB    = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] TRAP   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zext_q, zext_d;

    logic              mem_rdy;
    logic              m2r, rdst, iord, srca, zext;
    logic [1:0]        srcb, pcs;
    logic              irw, pcw, mw, rw, br, brne, done;
    logic [2:0]        alu3;
    logic [ALUC_W-1:0] alu_full;

    assign mem_rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        zext_d  = zext_q;
        m2r = 1'b0; rdst = 1'b0; iord = 1'b0; srca = 1'b0; zext = 1'b0;
        srcb = 2'b00; pcs = 2'b00;
        irw = 1'b0; pcw = 1'b0; mw = 1'b0; rw = 1'b0; br = 1'b0; brne = 1'b0;
        done = 1'b0;
        alu3 = ALU_ADD;
        case (state_q)
            FETCH: begin
                srcb = 2'b01;
                irw  = mem_rdy;
                pcw  = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                srcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_R:                     state_d = EXEC_R;
                    OP_BEQ, OP_BNE:           state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = EXEC_I;
                    OP_J:                     state_d = JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                  state_d = TRAP;
`else
                    default:                  state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                srca    = 1'b1;
                srcb    = 2'b10;
                state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                m2r     = 1'b1;
                rw      = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
                if (mem_rdy) begin
                    done    = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                srca    = 1'b1;
                state_d = ALUWB;
                case (bus.funct)
                    6'b100000: alu3 = ALU_ADD;
                    6'b100010: alu3 = ALU_SUB;
                    6'b100100: alu3 = ALU_AND;
                    6'b100101: alu3 = ALU_OR;
                    6'b101010: alu3 = ALU_SLT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:   state_d = TRAP;
`else
                    default:   alu3 = ALU_ADD;
`endif
                endcase
            end
            ALUWB: begin
                rdst    = 1'b1;
                rw      = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            EXEC_I: begin
                srca = 1'b1;
                srcb = 2'b10;
                case (bus.opcode)
                    OP_ANDI: begin alu3 = ALU_AND; zext = 1'b1; end
                    OP_ORI:  begin alu3 = ALU_OR;  zext = 1'b1; end
                    default: alu3 = ALU_ADD;
                endcase
                zext_d  = zext;
                state_d = IWB;
            end
            IWB: begin
                // IR is not consulted here; the extension mode comes from EXEC_I.
                zext    = zext_q;
                rw      = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                srca    = 1'b1;
                alu3    = ALU_SUB;
                pcs     = 2'b01;
                br      = (bus.opcode == OP_BEQ);
                brne    = (bus.opcode == OP_BNE);
                done    = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                pcs     = 2'b10;
                pcw     = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    assign cnt_d = done ? (cnt_q + CNT_W'(1)) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            zext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zext_q  <= zext_d;
        end
    end

    always_comb begin
        alu_full      = '0;
        alu_full[2:0] = alu3;
    end

    // Strobes are forced low while reset is asserted so an aborted access writes nothing.
    assign bus.ir_write    = irw  & rst_n;
    assign bus.pc_write    = pcw  & rst_n;
    assign bus.mem_write   = mw   & rst_n;
    assign bus.reg_write   = rw   & rst_n;
    assign bus.branch      = br   & rst_n;
    assign bus.branch_ne   = brne & rst_n;
    assign bus.instr_done  = done & rst_n;

    assign bus.mem_to_reg  = m2r;
    assign bus.reg_dst     = rdst;
    assign bus.i_or_d      = iord;
    assign bus.alu_src_a   = srca;
    assign bus.zero_ext    = zext;
    assign bus.alu_src_b   = srcb;
    assign bus.pc_src      = pcs;
    assign bus.alu_control = alu_full;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal     = (state_q == TRAP);
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle vector table plus hand sequences for reset, wrap and illegal ops.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.ALUC_W(4), .CNT_W(4)) bus ();
    multicycle_ctrl_fsm #(.ALUC_W(4), .CNT_W(4), .MEM_WAIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                           S_MW = 4'd5, S_XR = 4'd6, S_AWB = 4'd7, S_BR = 4'd8, S_XI = 4'd9,
                           S_IWB = 4'd10, S_J = 4'd11, S_TRAP = 4'd12;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;

    // {mem_to_reg, reg_dst, i_or_d, alu_src_a, zero_ext, alu_src_b, pc_src, ir_write, pc_write, mem_write, reg_write, branch, branch_ne}
    localparam logic [14:0] C_F1   = {5'b00000, 2'b01, 2'b00, 6'b110000};
    localparam logic [14:0] C_F0   = {5'b00000, 2'b01, 2'b00, 6'b000000};
    localparam logic [14:0] C_DEC  = {5'b00000, 2'b11, 2'b00, 6'b000000};
    localparam logic [14:0] C_MA   = {5'b00010, 2'b10, 2'b00, 6'b000000};
    localparam logic [14:0] C_MR   = {5'b00100, 2'b00, 2'b00, 6'b000000};
    localparam logic [14:0] C_MWB  = {5'b10000, 2'b00, 2'b00, 6'b000100};
    localparam logic [14:0] C_MW   = {5'b00100, 2'b00, 2'b00, 6'b001000};
    localparam logic [14:0] C_XR   = {5'b00010, 2'b00, 2'b00, 6'b000000};
    localparam logic [14:0] C_AWB  = {5'b01000, 2'b00, 2'b00, 6'b000100};
    localparam logic [14:0] C_BEQ  = {5'b00010, 2'b00, 2'b01, 6'b000010};
    localparam logic [14:0] C_BNE  = {5'b00010, 2'b00, 2'b01, 6'b000001};
    localparam logic [14:0] C_J    = {5'b00000, 2'b00, 2'b10, 6'b010000};
    localparam logic [14:0] C_XIZ  = {5'b00011, 2'b10, 2'b00, 6'b000000};
    localparam logic [14:0] C_XI   = {5'b00010, 2'b10, 2'b00, 6'b000000};
    localparam logic [14:0] C_IWBZ = {5'b00001, 2'b00, 2'b00, 6'b000100};
    localparam logic [14:0] C_IWB  = {5'b00000, 2'b00, 2'b00, 6'b000100};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [2:0]  alu;
        logic        done;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt;
    int   n_jumps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ctl_now();
        return {bus.mem_to_reg, bus.reg_dst, bus.i_or_d, bus.alu_src_a, bus.zero_ext,
                bus.alu_src_b, bus.pc_src, bus.ir_write, bus.pc_write, bus.mem_write,
                bus.reg_write, bus.branch, bus.branch_ne};
    endfunction

    // Called at a falling edge: drive, settle, compare, advance to the next falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.mem_ready = v.mr;
        #1;
        chk({tag, " state"}, 32'(bus.state), 32'(v.st));
        chk({tag, " ctl"},   32'(ctl_now()), 32'(v.ctl));
        chk({tag, " alu"},   32'(bus.alu_control), 32'(v.alu));
        chk({tag, " done"},  32'(bus.instr_done), 32'(v.done));
        chk({tag, " count"}, 32'(bus.instr_count), 32'(v.cnt));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [5:0] op, fn, input logic mr, input logic [3:0] st,
                                input logic [14:0] ctl, input logic [2:0] alu, input logic done,
                                input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.ctl = ctl; v.alu = alu; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic add(input logic [5:0] op, fn, input logic mr, input logic [3:0] st,
                       input logic [14:0] ctl, input logic [2:0] alu, input logic done, input logic [3:0] cnt);
        tbl.push_back(mk(op, fn, mr, st, ctl, alu, done, cnt));
    endtask

    task automatic add_head(input logic [5:0] op, fn, input logic [3:0] cnt);
        add(op, fn, 1'b1, S_F, C_F1,  A_ADD, 1'b0, cnt);
        add(op, fn, 1'b1, S_D, C_DEC, A_ADD, 1'b0, cnt);
    endtask

    task automatic add_r(input logic [5:0] fn, input logic [2:0] alu, input logic [3:0] cnt);
        add_head(OP_R, fn, cnt);
        add(OP_R, fn, 1'b1, S_XR,  C_XR,  alu,   1'b0, cnt);
        add(OP_R, fn, 1'b1, S_AWB, C_AWB, A_ADD, 1'b1, cnt);
    endtask

    task automatic add_i(input logic [5:0] op, input logic [14:0] cx, cw, input logic [2:0] alu, input logic [3:0] cnt);
        add_head(op, 6'd0, cnt);
        add(op, 6'd0, 1'b1, S_XI,  cx, alu,   1'b0, cnt);
        add(op, 6'd0, 1'b1, S_IWB, cw, A_ADD, 1'b1, cnt);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OP_R;
        bus.funct     = 6'd0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state",     32'(bus.state), 32'(S_F));
        chk("reset ir_write",  32'(bus.ir_write), 32'd0);
        chk("reset pc_write",  32'(bus.pc_write), 32'd0);
        chk("reset done",      32'(bus.instr_done), 32'd0);
        chk("reset count",     32'(bus.instr_count), 32'd0);
        chk("reset alu_src_b", 32'(bus.alu_src_b), 32'd1);

        add_r(6'b100000, A_ADD, 4'd0);
        add_head(OP_LW, 6'd0, 4'd1);
        add(OP_LW, 6'd0, 1'b1, S_MA,  C_MA,  A_ADD, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) add(OP_LW, 6'd0, 1'b0, S_MR, C_MR, A_ADD, 1'b0, 4'd1);
        add(OP_LW, 6'd0, 1'b1, S_MR,  C_MR,  A_ADD, 1'b0, 4'd1);
        add(OP_LW, 6'd0, 1'b1, S_MWB, C_MWB, A_ADD, 1'b1, 4'd1);
        add(OP_BAD, 6'd0, 1'b0, S_F, C_F0, A_ADD, 1'b0, 4'd2);
        add_head(OP_SW, 6'd0, 4'd2);
        add(OP_SW, 6'd0, 1'b1, S_MA, C_MA, A_ADD, 1'b0, 4'd2);
        add(OP_SW, 6'd0, 1'b0, S_MW, C_MW, A_ADD, 1'b0, 4'd2);
        add(OP_SW, 6'd0, 1'b1, S_MW, C_MW, A_ADD, 1'b1, 4'd2);
        add_head(OP_BNE, 6'd0, 4'd3);
        add(OP_BNE, 6'd0, 1'b1, S_BR, C_BNE, A_SUB, 1'b1, 4'd3);
        add_head(OP_BEQ, 6'd0, 4'd4);
        add(OP_BEQ, 6'd0, 1'b1, S_BR, C_BEQ, A_SUB, 1'b1, 4'd4);
        add_head(OP_J, 6'd0, 4'd5);
        add(OP_J, 6'd0, 1'b1, S_J, C_J, A_ADD, 1'b1, 4'd5);
        add_i(OP_ORI,  C_XIZ, C_IWBZ, A_OR,  4'd6);
        add_i(OP_ANDI, C_XIZ, C_IWBZ, A_AND, 4'd7);
        add_i(OP_ADDI, C_XI,  C_IWB,  A_ADD, 4'd8);
        add_r(6'b100010, A_SUB, 4'd9);
        add_r(6'b100100, A_AND, 4'd10);
        add_r(6'b100101, A_OR,  4'd11);
        add_r(6'b101010, A_SLT, 4'd12);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));
        exp_cnt = 13;

`ifndef CTRL_ILLEGAL_TRAP_EN
        run_vec(mk(OP_BAD, 6'd0, 1'b1, S_F,   C_F1,  A_ADD, 1'b0, 4'd13), "bad_op fetch");
        run_vec(mk(OP_BAD, 6'd0, 1'b1, S_D,   C_DEC, A_ADD, 1'b0, 4'd13), "bad_op decode");
        run_vec(mk(OP_R,   6'd0, 1'b1, S_F,   C_F1,  A_ADD, 1'b0, 4'd13), "bad_op back");
        run_vec(mk(OP_R,   6'd0, 1'b1, S_D,   C_DEC, A_ADD, 1'b0, 4'd13), "bad_fn decode");
        run_vec(mk(OP_R,   6'd0, 1'b1, S_XR,  C_XR,  A_ADD, 1'b0, 4'd13), "bad_fn exec");
        run_vec(mk(OP_R,   6'd0, 1'b1, S_AWB, C_AWB, A_ADD, 1'b1, 4'd13), "bad_fn wb");
        exp_cnt = 14;
`endif

        // Jumps carry the counter through 15 -> 0 and one step beyond.
        n_jumps = 16 - exp_cnt + 1;
        for (int i = 0; i < n_jumps; i++) begin
            run_vec(mk(OP_J, 6'd0, 1'b1, S_F, C_F1,  A_ADD, 1'b0, 4'(exp_cnt)), $sformatf("wrap%0d fetch", i));
            run_vec(mk(OP_J, 6'd0, 1'b1, S_D, C_DEC, A_ADD, 1'b0, 4'(exp_cnt)), $sformatf("wrap%0d decode", i));
            run_vec(mk(OP_J, 6'd0, 1'b1, S_J, C_J,   A_ADD, 1'b1, 4'(exp_cnt)), $sformatf("wrap%0d jump", i));
            exp_cnt = (exp_cnt + 1) % 16;
        end

        run_vec(mk(OP_SW, 6'd0, 1'b1, S_F,  C_F1,  A_ADD, 1'b0, 4'd1), "abort fetch");
        run_vec(mk(OP_SW, 6'd0, 1'b1, S_D,  C_DEC, A_ADD, 1'b0, 4'd1), "abort decode");
        run_vec(mk(OP_SW, 6'd0, 1'b1, S_MA, C_MA,  A_ADD, 1'b0, 4'd1), "abort memadr");
        run_vec(mk(OP_SW, 6'd0, 1'b0, S_MW, C_MW,  A_ADD, 1'b0, 4'd1), "abort memwr");
        bus.mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort state",     32'(bus.state), 32'(S_F));
        chk("abort mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort count",     32'(bus.instr_count), 32'd0);
        chk("abort done",      32'(bus.instr_done), 32'd0);
        chk("abort ir_write",  32'(bus.ir_write), 32'd0);
        @(negedge clk);
        chk("abort held", 32'(bus.state), 32'(S_F));
        rst_n = 1'b1;
        run_vec(mk(OP_J, 6'd0, 1'b1, S_F, C_F1,  A_ADD, 1'b0, 4'd0), "post fetch");
        run_vec(mk(OP_J, 6'd0, 1'b1, S_D, C_DEC, A_ADD, 1'b0, 4'd0), "post decode");
        run_vec(mk(OP_J, 6'd0, 1'b1, S_J, C_J,   A_ADD, 1'b1, 4'd0), "post jump");

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_vec(mk(OP_BAD, 6'd0, 1'b1, S_F, C_F1,  A_ADD, 1'b0, 4'd1), "trap fetch");
        run_vec(mk(OP_BAD, 6'd0, 1'b1, S_D, C_DEC, A_ADD, 1'b0, 4'd1), "trap decode");
        for (int i = 0; i < 3; i++) begin
            bus.opcode = OP_BAD;
            #1;
            chk($sformatf("trap%0d illegal", i), 32'(bus.illegal), 32'd1);
            run_vec(mk(OP_BAD, 6'd0, 1'b1, S_TRAP, 15'd0, A_ADD, 1'b0, 4'd1), $sformatf("trap%0d", i));
        end
        rst_n = 1'b0;
        #1;
        chk("trap reset state",   32'(bus.state), 32'(S_F));
        chk("trap reset illegal", 32'(bus.illegal), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
